// File: rtl/soc_optimsoc_functions.sv
// Shared helpers and constants for the SoC string/index conversion blocks.
// Holds the ASCII digit range, the decoder state type and a width helper.
package soc_optimsoc_functions;

   localparam logic [7:0] ASCII_ZERO = 8'd48;
   localparam logic [7:0] ASCII_NINE = 8'd57;

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_DRAIN = 2'd1,
      ST_EMIT  = 2'd2
   } s2i_state_e;

   // Bits needed to hold the values 0 .. n-1.
   function automatic int clog2_width(input longint n);
      int w;
      w = 0;
      while ((64'sd1 <<< w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/soc_string2index_digit.sv
// Classifies one ASCII character as a decimal digit and returns its value.
// Purely combinational; no latency and no flow control.
module soc_string2index_digit
   import soc_optimsoc_functions::*;
(
   input  logic [7:0] char_i,
   output logic       is_digit_o,
   output logic [3:0] value_o
);

   logic [7:0] offset;

   always_comb begin
      offset     = char_i - ASCII_ZERO;
      is_digit_o = (char_i >= ASCII_ZERO) && (char_i <= ASCII_NINE);
      value_o    = is_digit_o ? offset[3:0] : 4'd0;
   end

endmodule

// File: rtl/soc_string2index.sv
// Decodes a streamed ASCII decimal string (MSD first) into an integer with error flag.
// Result valid 1 cycle after the last beat; in_ready stays low until the result is taken.
module soc_string2index
   import soc_optimsoc_functions::*;
#(
   parameter int MAX_DIGITS  = 3,
   parameter int VALUE_WIDTH = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             in_char,
   input  logic                   in_last,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [VALUE_WIDTH-1:0] out_value,
   output logic                   out_error,
   output logic                   out_valid,
   input  logic                   out_ready
);

   localparam int ACC_W = VALUE_WIDTH + 4;
   localparam int CNT_W = (clog2_width(MAX_DIGITS + 1) < 1) ? 1 : clog2_width(MAX_DIGITS + 1);

   generate
      if (VALUE_WIDTH < clog2_width(10 ** MAX_DIGITS)) begin : g_width_chk
         $error("soc_string2index: VALUE_WIDTH too small for MAX_DIGITS");
      end
   endgenerate

   s2i_state_e        state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              ready_q;

   logic              is_digit;
   logic [3:0]        digit_val;
   logic              beat;
   logic              bad_beat;
   logic              acc_ovf;

   soc_string2index_digit u_digit (
      .char_i     (in_char),
      .is_digit_o (is_digit),
      .value_o    (digit_val)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ready_q <= 1'b1;
      end
   end

   // Upper accumulator bits can only be set if the width check above was bypassed.
   assign acc_ovf  = |acc_q[ACC_W-1:VALUE_WIDTH];
   assign beat     = in_valid && in_ready;
   assign bad_beat = !is_digit || (cnt_q == CNT_W'(MAX_DIGITS));

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_error = 1'b0;
      out_value = '0;

      case (state_q)
         ST_ACCUM: begin
            in_ready = ready_q;
            if (beat) begin
               if (bad_beat) begin
                  err_d = 1'b1;
               end else begin
                  acc_d = acc_q * ACC_W'(10) + ACC_W'(digit_val);
                  cnt_d = cnt_q + CNT_W'(1);
               end
               if (in_last) begin
                  state_d = ST_EMIT;
               end else if (bad_beat) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            in_ready = ready_q;
            if (beat && in_last) begin
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            out_valid = 1'b1;
            out_error = err_q || acc_ovf;
            out_value = out_error ? '0 : acc_q[VALUE_WIDTH-1:0];
            if (out_ready) begin
               state_d = ST_ACCUM;
               acc_d   = '0;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

endmodule

// File: tb/tb_soc_string2index.sv
// Directed and randomized bench for soc_string2index against a string-level reference model.
module tb_soc_string2index;

   localparam int MAXD = 3;
   localparam int VW   = 10;

   typedef byte unsigned bq_t[$];

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    in_char;
   logic          in_last;
   logic          in_valid;
   logic          in_ready;
   logic [VW-1:0] out_value;
   logic          out_error;
   logic          out_valid;
   logic          out_ready;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   soc_string2index #(.MAX_DIGITS(MAXD), .VALUE_WIDTH(VW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_char   (in_char),
      .in_last   (in_last),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_value (out_value),
      .out_error (out_error),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d", tag, obs, obs, exp);
      end
   endtask

   // Reference decode: digits accumulate, any non-digit or digit beyond MAXD poisons the string.
   function automatic void ref_decode(input bq_t s, output logic err, output int val);
      int n;
      err = 1'b0;
      n   = 0;
      val = 0;
      foreach (s[i]) begin
         if (!err) begin
            if (s[i] < 8'd48 || s[i] > 8'd57) err = 1'b1;
            else if (n == MAXD)               err = 1'b1;
            else begin
               val = val * 10 + (int'(s[i]) - 48);
               n++;
            end
         end
      end
      if (err) val = 0;
   endfunction

   function automatic bq_t index2string(input int v, input int width);
      string t;
      bq_t   q;
      t = $sformatf("%0d", v);
      while (t.len() < width) t = {"0", t};
      for (int i = 0; i < t.len(); i++) q.push_back(t[i]);
      return q;
   endfunction

   function automatic bq_t str2q(input string t);
      bq_t q;
      for (int i = 0; i < t.len(); i++) q.push_back(t[i]);
      return q;
   endfunction

   // Called at posedge+1; returns at posedge+1 just after the final beat transferred.
   task automatic send_str(input bq_t s, input bit mark_last, input bit gaps);
      foreach (s[i]) begin
         int g;
         int t;
         g = gaps ? int'($urandom_range(0, 1)) : 0;
         repeat (g) begin
            @(posedge clk); #1;
         end
         in_char  = s[i];
         in_last  = mark_last && (i == s.size() - 1);
         in_valid = 1'b1;
         t = 0;
         while (in_ready !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
         end
         chk("beat_accepted", {31'd0, in_ready}, 32'd1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   task automatic take_result(input string tag, input logic exp_err, input int exp_val, input int hold);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_value"}, 32'(out_value), 32'(exp_val));
      chk({tag, "_error"}, {31'd0, out_error}, {31'd0, exp_err});
      chk({tag, "_inrdy_emit"}, {31'd0, in_ready}, 32'd0);
      repeat (hold) begin
         @(posedge clk); #1;
         chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
         chk({tag, "_hold_value"}, 32'(out_value), 32'(exp_val));
         chk({tag, "_hold_inrdy"}, {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_consumed"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_inrdy_after"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic run_model(input string tag, input bq_t s, input int hold);
      logic e;
      int   v;
      ref_decode(s, e, v);
      send_str(s, 1'b1, 1'b1);
      take_result(tag, e, v, hold);
   endtask

   initial begin
      logic e;
      int   v;
      bq_t  s;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_char   = 8'd0;
      in_last   = 1'b0;
      out_ready = 1'b0;

      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_value", 32'(out_value), 32'd0);
      chk("rst_out_error", {31'd0, out_error}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      chk("in_ready_after_edge", {31'd0, in_ready}, 32'd1);

      send_str(str2q("123"), 1'b1, 1'b0);
      take_result("s123", 1'b0, 123, 0);
      send_str(str2q("007"), 1'b1, 1'b0);
      take_result("s007", 1'b0, 7, 0);
      send_str(str2q("999"), 1'b1, 1'b0);
      take_result("s999", 1'b0, 999, 0);
      send_str(str2q("1234"), 1'b1, 1'b0);
      take_result("s1234", 1'b1, 0, 0);
      send_str(str2q("1A25"), 1'b1, 1'b0);
      take_result("s1A25", 1'b1, 0, 0);
      send_str(str2q("5"), 1'b1, 1'b0);
      take_result("s5", 1'b0, 5, 0);
      send_str(str2q("Z"), 1'b1, 1'b0);
      take_result("sZ", 1'b1, 0, 0);
      send_str(str2q("42"), 1'b1, 1'b0);
      take_result("s42_hold", 1'b0, 42, 5);
      send_str(str2q("3"), 1'b1, 1'b0);
      take_result("s3_after_hold", 1'b0, 3, 0);

      // Reset in the middle of a string.
      send_str(str2q("56"), 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_out_value", 32'(out_value), 32'd0);
      chk("midrst_out_error", {31'd0, out_error}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1;
      send_str(str2q("8"), 1'b1, 1'b0);
      take_result("s8_after_rst", 1'b0, 8, 0);

      // Reset while a result is pending.
      send_str(str2q("9"), 1'b1, 1'b0);
      chk("emitrst_pending", {31'd0, out_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("emitrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("emitrst_out_value", 32'(out_value), 32'd0);
      @(posedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("emitrst_no_result", {31'd0, out_valid}, 32'd0);
      send_str(str2q("61"), 1'b1, 1'b0);
      take_result("s61_after_rst", 1'b0, 61, 0);

      // Round trip over the full value range with random zero padding.
      for (int val = 0; val < 1000; val++) begin
         int w;
         w = $urandom_range(1, MAXD);
         s = index2string(val, w);
         ref_decode(s, e, v);
         chk("roundtrip_model", 32'(v), 32'(val));
         send_str(s, 1'b1, 1'b1);
         take_result("roundtrip", 1'b0, val, 0);
      end

      // Random strings mixing digits, punctuation and arbitrary bytes.
      for (int n = 0; n < 300; n++) begin
         int len;
         bq_t r;
         len = $urandom_range(1, 5);
         for (int k = 0; k < len; k++) begin
            int p;
            p = $urandom_range(0, 9);
            if (p < 7)       r.push_back(byte'(8'd48 + 8'($urandom_range(0, 9))));
            else if (p == 7) r.push_back(8'd47);
            else if (p == 8) r.push_back(8'd58);
            else             r.push_back(byte'($urandom_range(0, 255)));
         end
         run_model("random", r, $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
